// File: rtl/mmio_gpo_ctrl_if.sv
// MCS I/O bus slot seen by the GPO controller: select, strobes, address and data.
interface mmio_gpo_ctrl_if;
  logic        cs;
  logic        write;
  logic        read;
  logic [4:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output cs, write, read, addr, write_data, input read_data);
  modport slave  (input cs, write, read, addr, write_data, output read_data);
endinterface

// File: rtl/mmio_gpo_ctrl.sv
// General-purpose output port with atomic SET/CLR/TOG, timed one-shot pulse and readback.
// Optional per-bit blink is compiled in when GPO_BLINK_EN is defined.
module mmio_gpo_ctrl #(
  parameter int W         = 8,
  parameter int PULSE_DEF = 1000,
  parameter int BLINK_DIV = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mmio_gpo_ctrl_if.slave        bus,
  output logic [W-1:0]          d_out
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam logic [15:0] LEN_RST = 16'(PULSE_DEF);

  state_e        state_q, state_d;
  logic [W-1:0]  out_q, out_d;
  logic [W-1:0]  pulseMask_q, pulseMask_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   len_q, len_d;

  logic          slotHit, wrEn, rdEn, pulseGo;
  logic [2:0]    regIdx;
  logic [W-1:0]  wdW;
  logic [W-1:0]  blinkView;
  logic [31:0]   outExt, maskExt, blinkExt, rdData;

  assign slotHit = (bus.addr[4:3] == 2'b00);
  assign wrEn    = bus.cs & bus.write & slotHit;
  assign rdEn    = bus.cs & bus.read & slotHit;
  assign regIdx  = bus.addr[2:0];
  assign wdW     = bus.write_data[W-1:0];
  assign pulseGo = wrEn && (regIdx == 3'd5) && (|wdW) && (|len_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      pulseMask_q <= '0;
      cnt_q       <= '0;
      len_q       <= LEN_RST;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      pulseMask_q <= pulseMask_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
    end
  end

  // Pulse update (including expiry clear) first, then CPU write, so the CPU wins on bits it touches.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    pulseMask_d = pulseMask_q;
    cnt_d       = cnt_q;
    len_d       = len_q;

    case (state_q)
      IDLE: begin
        if (pulseGo) begin
          out_d       = out_q | wdW;
          pulseMask_d = wdW;
          cnt_d       = len_q;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pulseGo) begin
          out_d       = out_q | wdW;
          pulseMask_d = pulseMask_q | wdW;
          cnt_d       = len_q;
        end else if (cnt_q == 16'd1) begin
          out_d       = out_q & ~pulseMask_q;
          pulseMask_d = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wrEn) begin
      case (regIdx)
        3'd0:    out_d = wdW;
        3'd1:    out_d = out_d | wdW;
        3'd2:    out_d = out_d & ~wdW;
        3'd3:    out_d = out_d ^ wdW;
        3'd4:    len_d = bus.write_data[15:0];
        default: ;
      endcase
    end
  end

`ifdef GPO_BLINK_EN
  logic [BLINK_DIV-1:0] prescale_q;
  logic                 phase_q;
  logic [W-1:0]         blinkMask_q;

  // Phase flips each time the free-running prescaler wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q  <= '0;
      phase_q     <= 1'b0;
      blinkMask_q <= '0;
    end else begin
      prescale_q <= prescale_q + BLINK_DIV'(1);
      if (&prescale_q) phase_q <= ~phase_q;
      if (wrEn && (regIdx == 3'd7)) blinkMask_q <= wdW;
    end
  end

  assign blinkView = blinkMask_q;
  assign d_out     = out_q ^ ({W{phase_q}} & blinkMask_q);
`else
  assign blinkView = '0;
  assign d_out     = out_q;
`endif

  always_comb begin
    outExt           = '0;
    outExt[W-1:0]    = out_q;
    maskExt          = '0;
    maskExt[W-1:0]   = pulseMask_q;
    blinkExt         = '0;
    blinkExt[W-1:0]  = blinkView;
  end

  always_comb begin
    rdData = '0;
    if (rdEn) begin
      case (regIdx)
        3'd0:    rdData = outExt;
        3'd4:    rdData = {16'b0, len_q};
        3'd5:    rdData = maskExt;
        3'd6:    rdData = {cnt_q, 15'b0, (state_q == ACTIVE)};
        3'd7:    rdData = blinkExt;
        default: rdData = '0;
      endcase
    end
  end

  assign bus.read_data = rdData;

endmodule
